falafel_header_lsu: RTL

Memory-side responder for the allocator's header request channel. Accepts one `header_req_t` at a time and performs the 64-bit word accesses implied by its `lsu_op`, including the atomic lock on the free list. Returns a `header_rsp_t` carrying the loaded or echoed header. Sits between the allocator control FSM and a single-outstanding word memory port.

---
 rtl/falafel_header_lsu_pkg.sv | 106 ++++++++++
 rtl/falafel_lsu_backoff.sv | 26 ++
 rtl/falafel_header_lsu.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/falafel_header_lsu_pkg.sv
// Shared types for the allocator header channel and the header LSU.
// Holds the request/response structs, the LSU op codes, LSU states and the per-beat access plan.
package falafel_header_lsu_pkg;

    localparam int unsigned WORD_SIZE = 8;
    localparam logic [63:0] BLOCK_NEXT_ADDR_OFFSET = 64'd8;

    typedef enum logic [2:0] {
        LSU_OP_LOCK         = 3'd0,
        LSU_OP_UNLOCK       = 3'd1,
        LSU_OP_LOAD         = 3'd2,
        LSU_OP_UPDATE       = 3'd3,
        LSU_OP_ALLOC_INSERT = 3'd4,
        LSU_OP_FREE_INSERT  = 3'd5,
        LSU_OP_DELETE       = 3'd6
    } req_lsu_op_e;

    typedef struct packed {
        logic [63:0] addr;
        logic [63:0] size;
        logic [63:0] next_addr;
    } header_t;

    typedef struct packed {
        logic        val;
        req_lsu_op_e lsu_op;
        header_t     header;
    } header_req_t;

    typedef struct packed {
        logic    val;
        header_t header;
    } header_rsp_t;

    typedef enum logic [2:0] {
        LSU_IDLE,
        LSU_ISSUE,
        LSU_WAIT,
        LSU_RSP
`ifdef FALAFEL_LSU_LOCK_BACKOFF_EN
        , LSU_BACKOFF
`endif
    } lsu_state_e;

    typedef struct packed {
        logic [63:0] addr;
        logic [63:0] wdata;
        logic        we;
        logic        amo;
    } mem_access_t;

    // Number of memory beats an op needs; 0 marks an op with no memory access.
    function automatic logic [1:0] op_beats(req_lsu_op_e op);
        case (op)
            LSU_OP_LOAD, LSU_OP_UPDATE, LSU_OP_FREE_INSERT:                  return 2'd2;
            LSU_OP_LOCK, LSU_OP_UNLOCK, LSU_OP_ALLOC_INSERT, LSU_OP_DELETE:  return 2'd1;
            default:                                                         return 2'd0;
        endcase
    endfunction

    // Memory access for a given op and beat; next_addr lives one word above the size field.
    function automatic mem_access_t plan_access(req_lsu_op_e op, logic beat, header_t hdr,
                                                logic [63:0] lock_addr);
        mem_access_t acc;
        logic [63:0] next_field;
        next_field = hdr.addr + BLOCK_NEXT_ADDR_OFFSET;
        acc = '0;
        case (op)
            LSU_OP_LOCK: begin
                acc.addr  = lock_addr;
                acc.wdata = 64'd1;
                acc.amo   = 1'b1;
            end
            LSU_OP_UNLOCK: begin
                acc.addr = lock_addr;
                acc.we   = 1'b1;
            end
            LSU_OP_LOAD: begin
                acc.addr = beat ? next_field : hdr.addr;
            end
            LSU_OP_UPDATE: begin
                acc.addr  = beat ? next_field : hdr.addr;
                acc.wdata = beat ? hdr.next_addr : hdr.size;
                acc.we    = 1'b1;
            end
            LSU_OP_ALLOC_INSERT: begin
                acc.addr  = hdr.addr;
                acc.wdata = hdr.size;
                acc.we    = 1'b1;
            end
            LSU_OP_FREE_INSERT: begin
                acc.addr  = beat ? hdr.addr : next_field;
                acc.wdata = beat ? hdr.size : hdr.next_addr;
                acc.we    = 1'b1;
            end
            LSU_OP_DELETE: begin
                acc.addr  = next_field;
                acc.wdata = hdr.next_addr;
                acc.we    = 1'b1;
            end
            default: acc = '0;
        endcase
        return acc;
    endfunction

endpackage

// File: rtl/falafel_lsu_backoff.sv
// Load/count-down timer: done is high once the loaded count has drained to zero.
module falafel_lsu_backoff #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             done
);

    logic [WIDTH-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_value;
        end else if (count_reg != '0) begin
            count_reg <= count_reg - 1'b1;
        end
    end

    assign done = (count_reg == '0);

endmodule

// File: rtl/falafel_header_lsu.sv
// Header LSU: turns one header request into sequential 64-bit word accesses and one response.
// Optional FALAFEL_LSU_LOCK_BACKOFF_EN inserts a BACKOFF_CYCLES idle gap after each failed LOCK swap.
module falafel_header_lsu
    import falafel_header_lsu_pkg::*;
#(
    parameter logic [63:0] LOCK_ADDR      = 64'h0,
    parameter int unsigned BACKOFF_CYCLES = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  header_req_t  req_i,
    output logic         req_ready_o,
    output header_rsp_t  rsp_o,
    input  logic         rsp_ready_i,
    output logic         mem_req_o,
    input  logic         mem_gnt_i,
    output logic         mem_we_o,
    output logic         mem_amo_o,
    output logic [63:0]  mem_addr_o,
    output logic [63:0]  mem_wdata_o,
    input  logic         mem_rvalid_i,
    input  logic [63:0]  mem_rdata_i
);

    lsu_state_e  state_reg, state_next;
    req_lsu_op_e op_reg, op_next;
    header_t     hdr_reg, hdr_next;
    logic        beat_reg, beat_next;
    mem_access_t acc;

`ifdef FALAFEL_LSU_LOCK_BACKOFF_EN
    logic backoff_load;
    logic backoff_done;

    falafel_lsu_backoff #(.WIDTH(32)) u_backoff (
        .clk        (clk_i),
        .srst       (rst_i),
        .load       (backoff_load),
        .load_value (32'(BACKOFF_CYCLES - 1)),
        .done       (backoff_done)
    );
`else
    logic unused_backoff_cfg;
    assign unused_backoff_cfg = (BACKOFF_CYCLES != 0);
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg <= LSU_IDLE;
            op_reg    <= LSU_OP_LOCK;
            hdr_reg   <= '0;
            beat_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            op_reg    <= op_next;
            hdr_reg   <= hdr_next;
            beat_reg  <= beat_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        op_next     = op_reg;
        hdr_next    = hdr_reg;
        beat_next   = beat_reg;
        acc         = plan_access(op_reg, beat_reg, hdr_reg, LOCK_ADDR);
        req_ready_o = 1'b0;
        rsp_o       = '0;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_amo_o   = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
`ifdef FALAFEL_LSU_LOCK_BACKOFF_EN
        backoff_load = 1'b0;
`endif
        case (state_reg)
            LSU_IDLE: begin
                // Held low while reset is asserted so nothing is accepted in the reset cycle.
                req_ready_o = !rst_i;
                if (req_i.val && !rst_i) begin
                    op_next    = req_i.lsu_op;
                    hdr_next   = req_i.header;
                    beat_next  = 1'b0;
                    state_next = (op_beats(req_i.lsu_op) == 2'd0) ? LSU_RSP : LSU_ISSUE;
                end
            end
            LSU_ISSUE: begin
                mem_req_o   = 1'b1;
                mem_we_o    = acc.we;
                mem_amo_o   = acc.amo;
                mem_addr_o  = acc.addr;
                mem_wdata_o = acc.wdata;
                if (mem_gnt_i) begin
                    state_next = LSU_WAIT;
                end
            end
            LSU_WAIT: begin
                if (mem_rvalid_i) begin
                    if (op_reg == LSU_OP_LOAD) begin
                        if (beat_reg) begin
                            hdr_next.next_addr = mem_rdata_i;
                        end else begin
                            hdr_next.size = mem_rdata_i;
                        end
                    end
                    if (op_reg == LSU_OP_LOCK && mem_rdata_i != '0) begin
`ifdef FALAFEL_LSU_LOCK_BACKOFF_EN
                        if (BACKOFF_CYCLES != 0) begin
                            backoff_load = 1'b1;
                            state_next   = LSU_BACKOFF;
                        end else begin
                            state_next = LSU_ISSUE;
                        end
`else
                        state_next = LSU_ISSUE;
`endif
                    end else if (!beat_reg && op_beats(op_reg) == 2'd2) begin
                        beat_next  = 1'b1;
                        state_next = LSU_ISSUE;
                    end else begin
                        state_next = LSU_RSP;
                    end
                end
            end
`ifdef FALAFEL_LSU_LOCK_BACKOFF_EN
            LSU_BACKOFF: begin
                if (backoff_done) begin
                    state_next = LSU_ISSUE;
                end
            end
`endif
            LSU_RSP: begin
                rsp_o.val    = 1'b1;
                rsp_o.header = hdr_reg;
                if (rsp_ready_i) begin
                    state_next = LSU_IDLE;
                end
            end
            default: state_next = LSU_IDLE;
        endcase
    end

endmodule
